rr_req_arbiter: RTL
===================

// Module: rr_req_arbiter
// PURPOSE
//  Round-robin arbiter that shares one downstream resource between 4 one-hot requesters.
//  Encodes the winner as a registered one-hot grant plus a 2-bit binary ID.
//  Rotating priority gives every requester a fair turn.
//  A grant is held while the winner keeps requesting, up to a hold limit.
//  Sits in front of any shared datapath that today consumes the 4-input encoder's (Y, valid) pair.
// PARAMETERS
//  MAX_HOLD   8   max consecutive grant cycles before preemption when others wait; 0 = never preempt
//  CNT_W      8   width of hold counter; MAX_HOLD must be < 2**CNT_W
// PORTS
//  clk        in   1   single clock; all state changes on rising edge
//  rst        in   1   synchronous, active-high reset
//  req        in   4   request per requester; held high until served/finished
//  gnt        out  4   registered one-hot grant, 0 when idle
//  gnt_id     out  2   binary index of granted requester (0 when idle)
//  gnt_valid  out  1   1 when gnt != 0
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, gnt=0, gnt_id=0, gnt_valid=0, hold_cnt=0. rst dominates all other inputs.
//  Pick function: first set bit of req scanning ptr, ptr+1, ... ptr+3 (mod 4).
//  IDLE:
//   - if req!=0, register pick -> state GRANT, hold_cnt=0.
//   - latency: req sampled high at edge k, gnt valid after edge k (1 cycle).
//   - else stay IDLE.
//  GRANT (winner w = gnt_id):
//   - release: req[w]==0 -> ptr=w+1 (mod 4).
//     If other req pending, grant next pick (using new ptr) at same edge, no idle bubble;
//     else gnt=0, go IDLE.
//   - preempt: MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1 && (req & ~gnt)!=0 -> ptr=w+1, grant next pick, hold_cnt=0.
//   - else keep w.
//     hold_cnt increments, saturating at 2**CNT_W-1.
//     A lone requester is never preempted.
//  Wrap-around: ptr 3 -> 0; pick scan wraps modulo 4.
//  Output relations:
//   - gnt always one-hot or zero.
//   - gnt_id consistent with gnt in the same cycle.
//   - gnt_valid == |gnt.
//  req changes while granted only affect the next decision; no combinational path req->gnt.
//  Reset mid-grant: outputs zero the cycle after rst is sampled; ptr returns to 0.
// STRUCTURE
//  Shared package arb_pkg:
//   - NUM_REQ=4, ID_W=2
//   - state enum {ST_IDLE, ST_GRANT}
//  Sub-module rr_priority_pick (combinational):
//   - rotate req by ptr
//   - 4-input priority encode to {valid, idx}
//   - add ptr back mod 4
//  Top holds FSM, ptr, hold_cnt and output registers.
// TESTING
//  1 rst, then req=1111 held -> after 1 edge gnt=0001, gnt_id=0, gnt_valid=1.
//  2 req0 alone 3 cycles, then req=1110 -> next edge gnt=0010, gnt_id=1, no gnt=0 cycle between.
//  3 MAX_HOLD=4, req=0011 constant -> gnt 0001 x4 cycles, 0010 x4, 0001 x4 ... repeating.
//  4 granted id3 drops req while req=1001 -> gnt=0001 (wrap), ptr=0 then 1 after release.
//  5 req=0100 only, 20 cycles, MAX_HOLD=4 -> gnt=0100 throughout, hold_cnt not wrapping.
//  6 rst asserted mid-grant with req=1111 -> next edge gnt=0, valid=0; after rst drops gnt=0001.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin request arbiter.
//   NUM_REQ     number of requesters sharing the downstream resource
//   ID_W        width of the binary requester index
//   arb_state_t arbiter FSM states
//   id_to_onehot  converts a binary requester index into a one-hot grant vector
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority pick.
// Returns the first asserted request found when scanning ptr, ptr+1, ... (mod NUM_REQ).
//   req    in   NUM_REQ  request vector
//   ptr    in   ID_W     index with highest priority
//   valid  out  1        at least one request is asserted
//   idx    out  ID_W     index of the chosen requester (0 when none)
module rr_priority_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W-1:0]      rot_idx;

    // Doubling the vector turns the rotation into a plain part-select:
    // req_rot[i] == req[(ptr + i) mod NUM_REQ].
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: NUM_REQ];

    always_comb begin
        rot_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = ID_W'(i);
            end
        end
    end

    assign valid = |req_rot;
    // ID_W-bit addition wraps naturally, undoing the rotation mod NUM_REQ.
    assign idx   = valid ? (rot_idx + ptr) : '0;

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter sharing one downstream resource between NUM_REQ requesters.
// Registered one-hot grant plus binary ID; the winner keeps the grant while it
// requests, until MAX_HOLD consecutive cycles when someone else is waiting.
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   req        in   NUM_REQ  request per requester
//   gnt        out  NUM_REQ  registered one-hot grant, 0 when idle
//   gnt_id     out  ID_W     binary index of the granted requester, 0 when idle
//   gnt_valid  out  1        grant present
//
// state    | meaning
// ST_IDLE  | no grant outstanding, waiting for any request
// ST_GRANT | gnt_id owns the resource; hold_cnt counts its extra cycles
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid
);

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    arb_state_t         state;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   hold_cnt;

    logic [ID_W-1:0]    pick_ptr;
    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;
    logic               winner_req;
    logic               others_wait;
    logic               preempt;

    // Any hand-over out of GRANT moves the pointer to winner+1, so the next
    // pick is computed from that pointer already in the same cycle.
    assign pick_ptr = (state == ST_GRANT) ? (gnt_id + ID_W'(1)) : ptr;

    rr_priority_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign winner_req  = |(req & gnt);
    assign others_wait = |(req & ~gnt);
    assign preempt     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && others_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state     <= ST_GRANT;
                        gnt       <= id_to_onehot(pick_idx);
                        gnt_id    <= pick_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!winner_req || preempt) begin
                        ptr      <= gnt_id + ID_W'(1);
                        hold_cnt <= '0;
                        if (pick_valid) begin
                            gnt       <= id_to_onehot(pick_idx);
                            gnt_id    <= pick_idx;
                            gnt_valid <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            gnt       <= '0;
                            gnt_id    <= '0;
                            gnt_valid <= 1'b0;
                        end
                    end else if (hold_cnt != CNT_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
